// File: rtl/branch_resolve.sv
// branch_resolve: ID-stage branch resolution and predictor-update unit.
//
// Keeps IF-stage predictions in a small in-order queue. When ID resolves a
// conditional branch, the real outcome is compared against the oldest queued
// prediction. The unit then drives predictor-update strobes and, on a
// mispredict, a flush/redirect toward pc_reg.
//
// Optional feature macro: BR_STATS_EN. When it is defined, saturating
// statistics counters are built. When it is undefined, both stat outputs are
// tied to 0.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   push_valid/pc/take/sel  prediction from IF; push_ready = queue not full (comb)
//   res_valid/pc/funct3/rs1/rs2/imm  branch to resolve in ID
//   id_is_branch          one-cycle update strobe to the predictor
//   id_take_or_not        actual outcome of the resolved branch
//   id_pre_true           prediction was correct
//   id_sel, id_pc         predictor component used, PC of the resolved branch
//   flush_o, flush_target_o  mispredict pulse and the correct next PC
//   count_o               queue occupancy
//   err_orphan_o          resolve without a matching prediction, or bad funct3
//   stat_branches_o, stat_mispred_o  statistics (BR_STATS_EN only)
module branch_resolve #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_valid,
   input  logic [31:0]       push_pc,
   input  logic              push_take,
   input  logic              push_sel,
   output logic              push_ready,
   input  logic              res_valid,
   input  logic [31:0]       res_pc,
   input  logic [2:0]        res_funct3,
   input  logic [31:0]       res_rs1,
   input  logic [31:0]       res_rs2,
   input  logic [31:0]       res_imm,
   output logic              id_is_branch,
   output logic              id_take_or_not,
   output logic              id_pre_true,
   output logic              id_sel,
   output logic [31:0]       id_pc,
   output logic              flush_o,
   output logic [31:0]       flush_target_o,
   output logic [PTR_W:0]    count_o,
   output logic              err_orphan_o,
   output logic [31:0]       stat_branches_o,
   output logic [31:0]       stat_mispred_o
);

   localparam int unsigned CNT_W = PTR_W + 1;

   typedef struct packed {
      logic [31:0] pc;
      logic        take;
      logic        sel;
   } entry_t;

   entry_t           queue [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;

   entry_t      head_entry;
   logic        actual_take;
   logic        bad_funct3;
   logic [31:0] actual_target;
   logic        match;
   logic        mispred;
   logic        push_acc;

   // Branch condition evaluation
   always_comb begin
      actual_take = 1'b0;
      bad_funct3  = 1'b0;
      unique case (res_funct3)
         3'b000:  actual_take = (res_rs1 == res_rs2);
         3'b001:  actual_take = (res_rs1 != res_rs2);
         3'b100:  actual_take = ($signed(res_rs1) <  $signed(res_rs2));
         3'b101:  actual_take = ($signed(res_rs1) >= $signed(res_rs2));
         3'b110:  actual_take = (res_rs1 <  res_rs2);
         3'b111:  actual_take = (res_rs1 >= res_rs2);
         default: bad_funct3  = 1'b1;
      endcase
   end

   assign actual_target = actual_take ? (res_pc + res_imm) : (res_pc + 32'd4);

   // Match against the oldest prediction. Push readiness uses the pre-pop count.
   // A push in a mispredict cycle is wrong-path and is dropped.
   assign head_entry = queue[head];
   assign match      = res_valid && (count != '0) && (head_entry.pc == res_pc);
   assign mispred    = match && (head_entry.take != actual_take);
   assign push_ready = (count != CNT_W'(DEPTH));
   assign push_acc   = push_valid && push_ready && !mispred;
   assign count_o    = count;

   // Queue storage (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (!rst && push_acc) begin
         queue[tail] <= '{pc: push_pc, take: push_take, sel: push_sel};
      end
   end

   // Pointers, occupancy and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         id_is_branch   <= 1'b0;
         id_take_or_not <= 1'b0;
         id_pre_true    <= 1'b0;
         id_sel         <= 1'b0;
         id_pc          <= '0;
         flush_o        <= 1'b0;
         flush_target_o <= '0;
         err_orphan_o   <= 1'b0;
      end else begin
         if (mispred) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (match)    head <= head + PTR_W'(1);
            if (push_acc) tail <= tail + PTR_W'(1);
            count <= count + CNT_W'(push_acc) - CNT_W'(match);
         end
         id_is_branch <= match;
         flush_o      <= mispred;
         err_orphan_o <= res_valid && (!match || bad_funct3);
         if (match) begin
            id_take_or_not <= actual_take;
            id_pre_true    <= (head_entry.take == actual_take);
            id_sel         <= head_entry.sel;
            id_pc          <= res_pc;
         end
         if (mispred) flush_target_o <= actual_target;
      end
   end

`ifdef BR_STATS_EN
   // Saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_branches_o <= '0;
         stat_mispred_o  <= '0;
      end else begin
         if (match && (stat_branches_o != '1))  stat_branches_o <= stat_branches_o + 32'd1;
         if (mispred && (stat_mispred_o != '1)) stat_mispred_o  <= stat_mispred_o + 32'd1;
      end
   end
`else
   assign stat_branches_o = '0;
   assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed test of branch_resolve.
// A queue-based reference model is checked against the DUT on every cycle.
// Literal expectations from the test plan pin the model itself.
module tb_branch_resolve;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PTR_W = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid;
   logic [31:0] push_pc;
   logic        push_take;
   logic        push_sel;
   logic        push_ready;
   logic        res_valid;
   logic [31:0] res_pc;
   logic [2:0]  res_funct3;
   logic [31:0] res_rs1;
   logic [31:0] res_rs2;
   logic [31:0] res_imm;
   logic        id_is_branch;
   logic        id_take_or_not;
   logic        id_pre_true;
   logic        id_sel;
   logic [31:0] id_pc;
   logic        flush_o;
   logic [31:0] flush_target_o;
   logic [PTR_W:0] count_o;
   logic        err_orphan_o;
   logic [31:0] stat_branches_o;
   logic [31:0] stat_mispred_o;

   branch_resolve #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_pc(push_pc), .push_take(push_take),
      .push_sel(push_sel), .push_ready(push_ready),
      .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
      .res_rs1(res_rs1), .res_rs2(res_rs2), .res_imm(res_imm),
      .id_is_branch(id_is_branch), .id_take_or_not(id_take_or_not),
      .id_pre_true(id_pre_true), .id_sel(id_sel), .id_pc(id_pc),
      .flush_o(flush_o), .flush_target_o(flush_target_o), .count_o(count_o),
      .err_orphan_o(err_orphan_o),
      .stat_branches_o(stat_branches_o), .stat_mispred_o(stat_mispred_o)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] pc;
      bit          take;
      bit          sel;
   } ent_t;

   ent_t        mq[$];
   bit          e_isb, e_take, e_pt, e_sel, e_flush, e_err;
   logic [31:0] e_pc, e_tgt, e_sb, e_sm;

   always @(posedge clk) begin
      bit          ready;
      bit          act;
      bit          bad;
      bit          mis;
      logic [31:0] rs1, rs2;
      if (rst) begin
         mq.delete();
         {e_isb, e_take, e_pt, e_sel, e_flush, e_err} = '0;
         e_pc = '0; e_tgt = '0; e_sb = '0; e_sm = '0;
      end else begin
         ready   = (mq.size() < DEPTH);
         mis     = 1'b0;
         e_isb   = 1'b0;
         e_flush = 1'b0;
         e_err   = 1'b0;
         if (res_valid) begin
            rs1 = res_rs1;
            rs2 = res_rs2;
            bad = 1'b0;
            case (res_funct3)
               3'd0: act = (rs1 == rs2);
               3'd1: act = (rs1 != rs2);
               3'd4: act = ($signed(rs1) <  $signed(rs2));
               3'd5: act = ($signed(rs1) >= $signed(rs2));
               3'd6: act = (rs1 <  rs2);
               3'd7: act = (rs1 >= rs2);
               default: begin act = 1'b0; bad = 1'b1; end
            endcase
            if (mq.size() > 0 && mq[0].pc == res_pc) begin
               e_isb  = 1'b1;
               e_take = act;
               e_pt   = (mq[0].take == act);
               e_sel  = mq[0].sel;
               e_pc   = res_pc;
               e_err  = bad;
               void'(mq.pop_front());
`ifdef BR_STATS_EN
               if (e_sb != 32'hFFFF_FFFF) e_sb = e_sb + 1;
`endif
               if (!e_pt) begin
                  mis     = 1'b1;
                  e_flush = 1'b1;
                  e_tgt   = act ? res_pc + res_imm : res_pc + 32'd4;
                  mq.delete();
`ifdef BR_STATS_EN
                  if (e_sm != 32'hFFFF_FFFF) e_sm = e_sm + 1;
`endif
               end
            end else begin
               e_err = 1'b1;
            end
         end
         if (push_valid && ready && !mis)
            mq.push_back('{pc: push_pc, take: push_take, sel: push_sel});
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("push_ready",     32'(push_ready),     32'(mq.size() < DEPTH));
         chk("count_o",        32'(count_o),        32'(mq.size()));
         chk("id_is_branch",   32'(id_is_branch),   32'(e_isb));
         chk("id_take_or_not", 32'(id_take_or_not), 32'(e_take));
         chk("id_pre_true",    32'(id_pre_true),    32'(e_pt));
         chk("id_sel",         32'(id_sel),         32'(e_sel));
         chk("id_pc",          id_pc,               e_pc);
         chk("flush_o",        32'(flush_o),        32'(e_flush));
         chk("flush_target_o", flush_target_o,      e_tgt);
         chk("err_orphan_o",   32'(err_orphan_o),   32'(e_err));
         chk("stat_branches",  stat_branches_o,     e_sb);
         chk("stat_mispred",   stat_mispred_o,      e_sm);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      push_valid = 1'b0; push_pc = '0; push_take = 1'b0; push_sel = 1'b0;
      res_valid = 1'b0; res_pc = '0; res_funct3 = '0;
      res_rs1 = '0; res_rs2 = '0; res_imm = '0;
   endtask

   task automatic push(input logic [31:0] pc, input bit take, input bit sel);
      push_valid = 1'b1; push_pc = pc; push_take = take; push_sel = sel;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm);
      res_valid = 1'b1; res_pc = pc; res_funct3 = f3;
      res_rs1 = a; res_rs2 = b; res_imm = imm;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst count",      32'(count_o), 32'd0);
      chk("rst push_ready", 32'(push_ready), 32'd1);
      chk("rst flush",      32'(flush_o), 32'd0);
      rst = 1'b0;

      // Correct not-taken
      push(32'h100, 1'b0, 1'b0); tick();
      resolve(32'h100, 3'b000, 32'd1, 32'd2, 32'h20); tick();
      chk("nt isb",   32'(id_is_branch), 32'd1);
      chk("nt take",  32'(id_take_or_not), 32'd0);
      chk("nt pt",    32'(id_pre_true), 32'd1);
      chk("nt flush", 32'(flush_o), 32'd0);
      chk("nt count", 32'(count_o), 32'd0);
      tick();
      chk("isb pulse", 32'(id_is_branch), 32'd0);

      // Mispredict taken, younger entry discarded
      push(32'h200, 1'b0, 1'b1); tick();
      push(32'h210, 1'b1, 1'b0); tick();
      resolve(32'h200, 3'b001, 32'd5, 32'd6, 32'h40); tick();
      chk("mp flush",  32'(flush_o), 32'd1);
      chk("mp target", flush_target_o, 32'h240);
      chk("mp sel",    32'(id_sel), 32'd1);
      chk("mp count",  32'(count_o), 32'd0);

      // Signed vs unsigned
      push(32'h300, 1'b1, 1'b0); tick();
      resolve(32'h300, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h80); tick();
      chk("blt take",  32'(id_take_or_not), 32'd1);
      chk("blt flush", 32'(flush_o), 32'd0);
      push(32'h304, 1'b1, 1'b0); tick();
      resolve(32'h304, 3'b110, 32'hFFFF_FFFF, 32'd1, 32'h80); tick();
      chk("bltu take",   32'(id_take_or_not), 32'd0);
      chk("bltu target", flush_target_o, 32'h308);
      push(32'h310, 1'b0, 1'b1); tick();
      resolve(32'h310, 3'b111, 32'd1, 32'hFFFF_FFFF, 32'h8); tick();
      chk("bgeu take", 32'(id_take_or_not), 32'd0);
      push(32'h314, 1'b1, 1'b0); tick();
      resolve(32'h314, 3'b101, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0); tick();
      chk("bge take",  32'(id_take_or_not), 32'd1);

      // Full queue, drops, simultaneous push/pop, pointer wrap
      for (int i = 0; i < 4; i++) begin
         push(32'h400 + 32'(4 * i), 1'b0, 1'(i)); tick();
      end
      chk("full count", 32'(count_o), 32'd4);
      chk("full ready", 32'(push_ready), 32'd0);
      push(32'h410, 1'b0, 1'b0); tick();
      chk("drop count", 32'(count_o), 32'd4);
      resolve(32'h400, 3'b000, 32'd1, 32'd2, 32'h0); push(32'h414, 1'b0, 1'b0); tick();
      chk("full pop+push", 32'(count_o), 32'd3);
      resolve(32'h404, 3'b000, 32'd1, 32'd2, 32'h0); push(32'h418, 1'b0, 1'b1); tick();
      chk("pop+push count", 32'(count_o), 32'd3);
      chk("pop 404 sel",    32'(id_sel), 32'd1);
      resolve(32'h408, 3'b000, 32'd1, 32'd2, 32'h0); tick();
      chk("order 408", id_pc, 32'h408);
      resolve(32'h40C, 3'b000, 32'd1, 32'd2, 32'h0); tick();
      chk("order 40C", id_pc, 32'h40C);
      resolve(32'h418, 3'b000, 32'd1, 32'd2, 32'h0); tick();
      chk("order 418", id_pc, 32'h418);
      chk("drain count", 32'(count_o), 32'd0);

      // Orphans: empty queue, then PC mismatch
      resolve(32'h300, 3'b000, 32'd0, 32'd0, 32'h0); tick();
      chk("orphan err",   32'(err_orphan_o), 32'd1);
      chk("orphan isb",   32'(id_is_branch), 32'd0);
      chk("orphan flush", 32'(flush_o), 32'd0);
      push(32'h500, 1'b0, 1'b0); tick();
      resolve(32'h504, 3'b000, 32'd0, 32'd0, 32'h0); tick();
      chk("mismatch err",   32'(err_orphan_o), 32'd1);
      chk("mismatch count", 32'(count_o), 32'd1);

      // Reset mid-stream with count 3; inputs ignored during reset
      push(32'h520, 1'b0, 1'b0); tick();
      push(32'h524, 1'b0, 1'b0); tick();
      chk("pre-rst count", 32'(count_o), 32'd3);
      rst = 1'b1;
      push(32'h528, 1'b0, 1'b0);
      resolve(32'h500, 3'b000, 32'd0, 32'd0, 32'h0);
      tick();
      rst = 1'b0;
      chk("rst count",  32'(count_o), 32'd0);
      chk("rst id_pc",  id_pc, 32'd0);
      chk("rst target", flush_target_o, 32'd0);
      chk("rst err",    32'(err_orphan_o), 32'd0);

      // Three resolves, last one mispredicted
      push(32'h600, 1'b0, 1'b0); tick();
      push(32'h604, 1'b0, 1'b0); tick();
      push(32'h608, 1'b0, 1'b0); tick();
      resolve(32'h600, 3'b000, 32'd1, 32'd2, 32'h10); tick();
      resolve(32'h604, 3'b000, 32'd1, 32'd2, 32'h10); tick();
      resolve(32'h608, 3'b000, 32'd3, 32'd3, 32'h10); tick();
      chk("stat flush target", flush_target_o, 32'h618);
`ifdef BR_STATS_EN
      chk("stat branches", stat_branches_o, 32'd3);
      chk("stat mispred",  stat_mispred_o,  32'd1);
`else
      chk("stat branches", stat_branches_o, 32'd0);
      chk("stat mispred",  stat_mispred_o,  32'd0);
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
